// File: rtl/ppfifo_put_arbiter_pkg.sv
// Shared constants and FSM state type for the PushPullFIFO put-side arbiter.
package ppfifo_put_arbiter_pkg;

    localparam int unsigned FIFO_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_ACK
    } ppfifo_arb_state_t;

endpackage

// File: rtl/ppfifo_rr_picker.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module ppfifo_rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid_c,
    output logic [IDX_W-1:0]   next_idx_c
);

    int unsigned cand;

    always_comb begin
        valid_c    = 1'b0;
        next_idx_c = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c    = 1'b1;
                next_idx_c = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ppfifo_put_arbiter.sv
// Round-robin sharing of the PushPullFIFO put port between NUM_REQ four-phase producers.
// Optional grant counter output enabled by PPFIFO_ARB_GRANT_COUNT_EN.
module ppfifo_put_arbiter
    import ppfifo_put_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned FIFO_WORD_SIZE = FIFO_WIDTH,
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
    parameter  int unsigned COUNT_WIDTH    = 16,
`endif
    localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                                clock,
    input  logic                                clear_n,
    input  logic [NUM_REQ-1:0]                  req_put_req,
    input  logic [NUM_REQ*FIFO_WORD_SIZE-1:0]   req_put_value,
    output logic [NUM_REQ-1:0]                  req_put_ack,
    output logic                                fifo_put_req,
    output logic [FIFO_WORD_SIZE-1:0]           fifo_put_value,
    input  logic                                fifo_put_ack,
    output logic [IDX_W-1:0]                    grant_id,
    output logic                                busy
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0]              grant_count
`endif
);

    ppfifo_arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [FIFO_WORD_SIZE-1:0] value_q, value_d;
    logic                      fifo_req_q, fifo_req_d;
    logic [NUM_REQ-1:0]        ack_q, ack_d;
    logic                      busy_q, busy_d;

    logic                      pick_valid_c;
    logic [IDX_W-1:0]          pick_idx_c;
    logic [FIFO_WORD_SIZE-1:0] words [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign words[g] = req_put_value[g*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
    end

    ppfifo_rr_picker #(
        .NUM_REQ    (NUM_REQ)
    ) u_picker (
        .req        (req_put_req),
        .last       (last_q),
        .valid_c    (pick_valid_c),
        .next_idx_c (pick_idx_c)
    );

`ifdef PPFIFO_ARB_GRANT_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        value_d    = value_q;
        fifo_req_d = fifo_req_q;
        ack_d      = ack_q;
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
        count_d    = count_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid_c) begin
                    grant_d    = pick_idx_c;
                    value_d    = words[pick_idx_c];
                    fifo_req_d = 1'b1;
                    state_d    = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (fifo_put_ack) begin
                    fifo_req_d     = 1'b0;
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ARB_ACK;
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
`endif
                end
            end
            ARB_ACK: begin
                // Four-phase return: both producer and FIFO must have dropped.
                if (!req_put_req[grant_q] && !fifo_put_ack) begin
                    ack_d   = '0;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            value_q    <= '0;
            fifo_req_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
            count_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            value_q    <= value_d;
            fifo_req_q <= fifo_req_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
            count_q    <= count_d;
`endif
        end
    end

    assign req_put_ack    = ack_q;
    assign fifo_put_req   = fifo_req_q;
    assign fifo_put_value = value_q;
    assign grant_id       = grant_q;
    assign busy           = busy_q;
`ifdef PPFIFO_ARB_GRANT_COUNT_EN
    assign grant_count    = count_q;
`endif

endmodule
